// File: rtl/instruction_fetch_pkg.sv
// Shared constants and fault rule for the fetch stage.
// The fault rule catches misaligned PCs and PCs past the end of instruction memory.
package instruction_fetch_pkg;
  localparam int unsigned XLEN           = 32;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam int unsigned IMEM_DEPTH_DEF = 64;
  localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0013;

  function automatic logic fetch_fault(input logic [XLEN-1:0] addr,
                                       input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[XLEN-1:2]} >= depth);
  endfunction
endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory port plus the IF/ID handshake to decode.
// master = fetch stage, slave = memory/decoder side.
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;
  logic [XLEN-1:0] out_instr;
  logic            out_fault;

  modport master (
    output imem_addr, out_valid, out_pc, out_pc_plus4, out_instr, out_fault,
    input  imem_instr, out_ready
  );
  modport slave (
    input  imem_addr, out_valid, out_pc, out_pc_plus4, out_instr, out_fault,
    output imem_instr, out_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives instruction memory, registers the word into IF/ID.
// Redirects flush the held item; faulting fetches carry a NOP plus a fault flag.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int unsigned     IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR  = NOP_INSTR_DEF
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_target,
  output logic [XLEN-1:0]     fetch_count
);
  logic [XLEN-1:0] pc;
  logic            fault;
  logic            fire;

  assign bus.imem_addr = pc;
  assign fault         = fetch_fault(pc, IMEM_DEPTH);
  assign fire          = !bus.out_valid || bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc               <= RESET_PC;
      bus.out_valid    <= 1'b0;
      bus.out_pc       <= '0;
      bus.out_pc_plus4 <= '0;
      bus.out_instr    <= NOP_INSTR;
      bus.out_fault    <= 1'b0;
      fetch_count      <= '0;
    end else begin
      // A handoff counts even on the edge that flushes the stage.
      if (bus.out_valid && bus.out_ready)
        fetch_count <= fetch_count + 1'b1;
      if (redirect_valid) begin
        pc            <= redirect_target;
        bus.out_valid <= 1'b0;
      end else if (fire) begin
        bus.out_valid    <= 1'b1;
        bus.out_pc       <= pc;
        bus.out_pc_plus4 <= pc + 32'd4;
        bus.out_instr    <= fault ? NOP_INSTR : bus.imem_instr;
        bus.out_fault    <= fault;
        pc               <= pc + 32'd4;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboarded random test of instruction_fetch: a stream model predicts every handed-off item.
module tb_instruction_fetch;
  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        fault;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] fetch_count;
  logic [31:0] mem [DEPTH];

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(RPC), .IMEM_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign bus.imem_instr = ((bus.imem_addr >> 2) < DEPTH) ? mem[bus.imem_addr[7:2]] : 32'hDEAD_BEEF;

  int    total = 0, bad = 0, hs_total = 0;
  bit    mon_on = 0, done = 0;
  item_t expq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected stream after (re)starting at addr: consecutive words, faults from the address rules.
  task automatic restart_stream(input logic [31:0] addr);
    item_t it;
    logic [31:0] a;
    bit f;
    expq.delete();
    a = addr;
    for (int i = 0; i < 256; i++) begin
      f = (a % 4 != 0) || ((a / 4) >= DEPTH);
      it.pc    = a;
      it.pc4   = a + 32'd4;
      it.fault = f;
      it.instr = f ? NOP : mem[(a / 4) % DEPTH];
      expq.push_back(it);
      a = a + 32'd4;
    end
  endtask

  bit          pend = 0;
  logic [31:0] pend_tgt;

  task automatic step(input bit rdy, input bit rv, input logic [31:0] tgt, input bit rst);
    @(posedge clk);
    #1;
    if (pend) restart_stream(pend_tgt);
    bus.out_ready   = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    reset           = rst;
    pend     = rst || rv;
    pend_tgt = rst ? RPC : tgt;
  endtask

  // Monitor: at each negedge, check state left by the last edge and pop the item about to be taken.
  initial begin
    logic [31:0] mcount = 0;
    bit prev_rst = 0, prev_redir = 0, prev_stall = 0;
    logic [31:0] s_addr, s_pc, s_pc4, s_instr, s_cnt;
    logic s_fault;
    item_t it;
    while (!done) begin
      @(negedge clk);
      if (!mon_on) continue;
      if (prev_rst) begin
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_pc", bus.out_pc, 0);
        chk("rst_pc4", bus.out_pc_plus4, 0);
        chk("rst_instr", bus.out_instr, NOP);
        chk("rst_fault", 32'(bus.out_fault), 0);
        chk("rst_addr", bus.imem_addr, RPC);
      end
      if (prev_redir) chk("bubble_valid", 32'(bus.out_valid), 0);
      if (prev_stall) begin
        chk("stall_addr", bus.imem_addr, s_addr);
        chk("stall_valid", 32'(bus.out_valid), 1);
        chk("stall_pc", bus.out_pc, s_pc);
        chk("stall_pc4", bus.out_pc_plus4, s_pc4);
        chk("stall_instr", bus.out_instr, s_instr);
        chk("stall_fault", 32'(bus.out_fault), 32'(s_fault));
        chk("stall_count", fetch_count, s_cnt);
      end
      chk("fetch_count", fetch_count, mcount);
      if (reset) begin
        mcount = 0;
      end else if (bus.out_valid && bus.out_ready) begin
        hs_total++;
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard_empty got=handoff pc %h want=no handoff", bus.out_pc);
        end else begin
          it = expq.pop_front();
          chk("item_pc", bus.out_pc, it.pc);
          chk("item_pc4", bus.out_pc_plus4, it.pc4);
          chk("item_instr", bus.out_instr, it.instr);
          chk("item_fault", 32'(bus.out_fault), 32'(it.fault));
        end
        mcount = mcount + 1;
      end
      prev_rst   = reset;
      prev_redir = !reset && redirect_valid;
      prev_stall = !reset && !redirect_valid && bus.out_valid && !bus.out_ready;
      s_addr = bus.imem_addr; s_pc = bus.out_pc; s_pc4 = bus.out_pc_plus4;
      s_instr = bus.out_instr; s_fault = bus.out_fault; s_cnt = fetch_count;
    end
  end

  initial begin
    logic [31:0] t;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00a0_0113;
    bus.out_ready = 1'b0;
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    mon_on = 1;
    // Directed: straight-line, stall, redirect under stall, faults, wrap, reset mid-stall.
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 0, 0); step(0, 1, 32'h60, 0);
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 32'h102, 0); step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 32'h100, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 32'hFFFF_FFFC, 0); step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 1); step(1, 0, 0, 0);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    // Random phase.
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0: t = $urandom_range(0, DEPTH - 1) * 4;
        1: t = ($urandom_range(0, DEPTH - 1) * 4) | $urandom_range(1, 3);
        2: t = 32'h100 + ($urandom_range(0, 255) * 4);
        default: t = 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4);
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, t,
           $urandom_range(0, 199) == 0);
    end
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    done = 1;
    @(negedge clk);
    total++;
    if (hs_total < 100) begin
      bad++;
      $display("FAIL handoff_activity got=%0d want>=100", hs_total);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
